// File: rtl/alu_pkg.sv
// Shared opcode encoding and range constants for the registered ALU.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD            = 2'b00,
        SUB            = 2'b01,
        NOT_A          = 2'b10,
        REDUCTION_OR_B = 2'b11
    } opcode_e;

    // Operand range for the default 4-bit width.
    localparam int MAXPOS = 7;
    localparam int MAXNEG = -8;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the ALU and whoever drives it.
interface alu_if #(
    parameter int WIDTH = 4
);
    logic        [1:0]       Opcode;
    logic signed [WIDTH-1:0] A;
    logic signed [WIDTH-1:0] B;
    logic signed [WIDTH:0]   C;

    modport master (output Opcode, output A, output B, input  C);
    modport slave  (input  Opcode, input  A, input  B, output C);
endinterface

// File: rtl/alu_addsub.sv
// Combinational sign-extended adder/subtractor; the WIDTH+1 result never overflows.
module alu_addsub #(
    parameter int WIDTH = 4
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    sub,
    output logic signed [WIDTH:0]   sum
);
    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;

    assign a_ext = {a[WIDTH-1], a};
    assign b_ext = {b[WIDTH-1], b};

    // Add or subtract the widened operands.
    always_comb begin
        sum = '0;
        if (sub) begin
            sum = a_ext - b_ext;
        end else begin
            sum = a_ext + b_ext;
        end
    end
endmodule

// File: rtl/alu.sv
// Registered two's-complement ALU: add, subtract, invert A, reduction-OR of B.
// Result is WIDTH+1 bits and appears one clock after the operands are sampled.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    alu_if.slave        bus
);
    logic signed [WIDTH:0] addsub_res;
    logic signed [WIDTH:0] c_nxt;
    logic signed [WIDTH:0] c_p0;
    logic                  is_sub;
    opcode_e               op;

    // Sign-extend an operand to the result width.
    function automatic logic signed [WIDTH:0] sext(input logic signed [WIDTH-1:0] v);
        return {v[WIDTH-1], v};
    endfunction

    assign op     = opcode_e'(bus.Opcode);
    assign is_sub = (op == SUB);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (bus.A),
        .b   (bus.B),
        .sub (is_sub),
        .sum (addsub_res)
    );

    // Select the operation result feeding the output register.
    always_comb begin
        c_nxt = '0;
        case (op)
            ADD, SUB:       c_nxt = addsub_res;
            NOT_A:          c_nxt = ~sext(bus.A);
            REDUCTION_OR_B: c_nxt = {{WIDTH{1'b0}}, |bus.B};
            default:        c_nxt = '0;
        endcase
    end

    // ---- stage p0: output register, reset wins over any operation ----
    always_ff @(posedge clk) begin
        if (reset) begin
            c_p0 <= '0;
        end else begin
            c_p0 <= c_nxt;
        end
    end

    assign bus.C = c_p0;
endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU.
module tb_alu;
    import alu_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   errors;

    alu_if #(.WIDTH(4)) bus ();

    alu #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation, let a rising edge capture it, then settle.
    task automatic apply(input logic [1:0] op, input int a, input int b);
        bus.Opcode = op;
        bus.A      = 4'(a);
        bus.B      = 4'(b);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic signed [4:0] exp;
        reset = 1'b1;
        apply(ADD, 7, 7);
        tests++;
        if (bus.C !== 5'sd0) begin
            errors++;
            $display("FAIL reset_initial: C=%0d expected 0", bus.C);
        end
        reset = 1'b0;
        apply(ADD, 7, 7);
        exp = 5'sd14;
        tests++;
        if (bus.C !== exp) begin
            errors++;
            $display("FAIL reset_pre: C=%0d expected %0d", bus.C, exp);
        end
        reset = 1'b1;
        apply(SUB, -8, 7);
        tests++;
        if (bus.C !== 5'sd0) begin
            errors++;
            $display("FAIL reset_midstream: C=%0d expected 0", bus.C);
        end
        reset = 1'b0;
        apply(ADD, 3, 2);
        exp = 5'sd5;
        tests++;
        if (bus.C !== exp) begin
            errors++;
            $display("FAIL reset_release: C=%0d expected %0d", bus.C, exp);
        end
    endtask

    task automatic test_not_a;
        int a_v[3]   = '{-8, 7, 0};
        int exp_v[3] = '{7, -8, -1};
        logic signed [4:0] exp;
        for (int i = 0; i < 3; i++) begin
            apply(NOT_A, a_v[i], 5);
            exp = 5'(exp_v[i]);
            tests++;
            if (bus.C !== exp) begin
                errors++;
                $display("FAIL not_a[%0d]: A=%0d C=%0d expected %0d", i, a_v[i], bus.C, exp);
            end
        end
    endtask

    task automatic test_addsub;
        int a_v[9]   = '{-8, -8,  7, 7, -8,  0,  0, 7, 0};
        int b_v[9]   = '{-8,  7, -8, 7,  0, -8,  7, 0, 0};
        int add_v[9] = '{-16, -1, -1, 14, -8, -8, 7, 7, 0};
        int sub_v[9] = '{0, -15, 15, 0, -8, 8, -7, 7, 0};
        logic signed [4:0] exp;
        for (int i = 0; i < 9; i++) begin
            apply(ADD, a_v[i], b_v[i]);
            exp = 5'(add_v[i]);
            tests++;
            if (bus.C !== exp) begin
                errors++;
                $display("FAIL add[%0d]: A=%0d B=%0d C=%0d expected %0d", i, a_v[i], b_v[i], bus.C, exp);
            end
            apply(SUB, a_v[i], b_v[i]);
            exp = 5'(sub_v[i]);
            tests++;
            if (bus.C !== exp) begin
                errors++;
                $display("FAIL sub[%0d]: A=%0d B=%0d C=%0d expected %0d", i, a_v[i], b_v[i], bus.C, exp);
            end
        end
    endtask

    task automatic test_reduction_or;
        int a_v[3]   = '{7, -8, -1};
        int b_v[3]   = '{-8, 7, 0};
        int exp_v[3] = '{1, 1, 0};
        logic signed [4:0] exp;
        for (int i = 0; i < 3; i++) begin
            apply(REDUCTION_OR_B, a_v[i], b_v[i]);
            exp = 5'(exp_v[i]);
            tests++;
            if (bus.C !== exp) begin
                errors++;
                $display("FAIL redor[%0d]: B=%0d C=%0d expected %0d", i, b_v[i], bus.C, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] op_v[6] = '{ADD, SUB, ADD, SUB, NOT_A, ADD};
        int a_v[6]          = '{5, 5, -3, -3, 2, 1};
        int b_v[6]          = '{-6, -6, -4, -4, 0, 1};
        int exp_v[6]        = '{-1, 11, -7, 1, -3, 2};
        logic signed [4:0] exp;
        for (int i = 0; i < 6; i++) begin
            apply(op_v[i], a_v[i], b_v[i]);
            exp = 5'(exp_v[i]);
            tests++;
            if (bus.C !== exp) begin
                errors++;
                $display("FAIL b2b[%0d]: C=%0d expected %0d", i, bus.C, exp);
            end
        end
        // Inputs changing between edges must not disturb the held result.
        bus.Opcode = SUB;
        bus.A      = 4'sd7;
        bus.B      = -4'sd8;
        #3;
        tests++;
        if (bus.C !== 5'sd2) begin
            errors++;
            $display("FAIL hold_between_edges: C=%0d expected 2", bus.C);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.C !== 5'sd15) begin
            errors++;
            $display("FAIL hold_next_edge: C=%0d expected 15", bus.C);
        end
    endtask

    initial begin
        tests      = 0;
        errors     = 0;
        reset      = 1'b1;
        bus.Opcode = ADD;
        bus.A      = '0;
        bus.B      = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_not_a();
        test_addsub();
        test_reduction_or();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/alu.md
# alu

Registered 4-bit two's-complement ALU producing a 5-bit signed result. It performs add, subtract, bitwise invert of A and reduction-OR of B, selected by a 2-bit opcode. It is a leaf datapath block. Inputs are sampled on the rising clock edge and the result is held in an output register that downstream logic reads one cycle later.

## Interface
- Parameter `WIDTH`, default 4: operand width in bits; the result is `WIDTH+1` bits.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; one clock, reset is synchronous and active-high.
- `Opcode`  in  2: operation select.
- `A`  in  WIDTH: signed operand, two's complement.
- `B`  in  WIDTH: signed operand, two's complement.
- `C`  out  WIDTH+1: signed registered result, two's complement.

## Operation
- Opcode encoding:
  - `2'b00` ADD: C = A + B.
  - `2'b01` SUB: C = A − B.
  - `2'b10` NOT_A: C = ~A.
  - `2'b11` REDUCTION_OR_B: C = |B.
- ADD/SUB:
  - Both operands are sign-extended to WIDTH+1 bits before the operation.
  - The full result always fits, so there is no overflow, no saturation and no flags.
  - Range is −16..+15 for WIDTH=4.
- NOT_A: A is sign-extended to WIDTH+1 bits, then bitwise inverted.
  - Gives −A−1, e.g. ~(−8)=7, ~7=−8, ~0=−1.
- REDUCTION_OR_B: 1-bit OR of all bits of B, zero-extended.
  - C is 0 when B==0, otherwise +1.
- The datapath is fully combinational into the output register; there is no other internal state.
- Operands are plain vectors; no X-propagation handling is required.

## Timing
- Latency is one cycle. The register captures f(Opcode, A, B) at rising edge N, and C shows it until edge N+1.
- Reset:
  - When `reset`=1 at a rising edge, C becomes 0 regardless of Opcode, A or B.
  - Reset has priority over any operation.
  - The reset value of C is 5'sd0.
- After reset deasserts, the first rising edge registers a normal result.
- Reset asserted mid-stream discards the in-flight result; C reads 0 on the following cycle.
- Opcode or operand changes between edges have no effect until the next rising edge. There is no handshake; a new operation may be issued every cycle.
- Before the first reset, C is undefined. The testbench applies reset before checking.

## Structure
- Package `alu_pkg`:
  - Opcode enum or localparams: `ADD`=2'b00, `SUB`=2'b01, `NOT_A`=2'b10, `REDUCTION_OR_B`=2'b11.
  - Constants `MAXPOS`=7 and `MAXNEG`=−8 for the default WIDTH.
- Optional sub-module `alu_addsub`: combinational sign-extended adder/subtractor (WIDTH in, WIDTH+1 out, `sub` control), instantiated once.
- Top level: opcode mux (case with a default arm that drives 0) plus the output register with synchronous reset.

## Test plan
- Reset check: hold reset=1 for one edge with any inputs -> C==0 at the next sample. Also pulse reset mid-stream -> C==0.
- NOT_A boundaries: A=−8 -> 7; A=7 -> −8; A=0 -> −1, each sampled one cycle after issue.
- ADD/SUB extremes:
  - A=−8, B=−8 -> ADD −16, SUB 0.
  - A=−8, B=7 -> ADD −1, SUB −15.
  - A=7, B=−8 -> ADD −1, SUB 15.
  - A=7, B=7 -> ADD 14, SUB 0.
- ADD/SUB with zero:
  - A=−8, B=0 -> ADD −8, SUB −8.
  - A=0, B=−8 -> ADD −8, SUB 8.
  - A=0, B=7 -> ADD 7, SUB −7.
  - A=7, B=0 -> ADD 7, SUB 7.
  - A=0, B=0 -> ADD 0, SUB 0.
- REDUCTION_OR_B: B=−8 -> 1; B=7 -> 1; B=0 -> 0. A is ignored.
- Back-to-back issue: change Opcode every cycle (ADD then SUB with the same operands) -> C tracks each result with exactly one cycle of latency. The bench reports error and pass counts at the end.
